line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed pixel width.
REQ-002 Parameter IMG_WIDTH, default 16, pixels per row (>=3).
REQ-003 Parameter IMG_HEIGHT, default 16, rows per frame (>=3).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 Rst_linebuf  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  one-cycle pulse; begins a frame.
REQ-007 in_valid  input  1  in_pixel valid.
REQ-008 in_pixel  input  DATA_WIDTH signed  raster-order pixel stream.
REQ-009 in_ready  output  1  block accepts in_pixel.
REQ-010 out_row_n, out_row_n_1, out_row_n_2  output  DATA_WIDTH signed each  current-row, previous-row and two-rows-back values for one column; drive a 3x3 window register.
REQ-011 Wr_window  output  1  column-write strobe to window register.
REQ-012 Shift_window  output  1  shift strobe to window register.
REQ-013 win_valid  output  1  window register holds a complete 3x3 window.
REQ-014 frame_done  output  1  one-cycle pulse after last pixel accepted.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=0; Start=1 -> RUN, col=0, row=0.
REQ-017 RUN: in_ready=1; Start ignored.
REQ-018 Accept = in_valid && in_ready; in_valid low in RUN -> no strobes, counters and line memories hold.
REQ-019 Two line memories line1[0:IMG_WIDTH-1], line2[0:IMG_WIDTH-1], DATA_WIDTH each.
REQ-020 On accept at column c: line2[c]<=line1[c]; line1[c]<=in_pixel.
REQ-021 On accept: next cycle out_row_n=in_pixel, out_row_n_1=line1[c] (old value), out_row_n_2=line2[c] (old value); latency 1 cycle, all outputs registered.
REQ-022 Missing rows masked: row==0 -> out_row_n_1=0 and out_row_n_2=0; row==1 -> out_row_n_2=0.
REQ-023 Wr_window and Shift_window asserted together for exactly the cycle following each accept, deasserted otherwise; row outputs hold last value when strobes low.
REQ-024 win_valid asserted for one cycle, the cycle after a strobe cycle whose column had c>=2 and row>=2; otherwise 0.
REQ-025 Column counter wraps IMG_WIDTH-1 -> 0 and increments row; no windows span rows (REQ-024 gating).
REQ-026 Accept at row IMG_HEIGHT-1, col IMG_WIDTH-1 -> DONE; in_ready drops the following cycle.
REQ-027 DONE: frame_done=1 for one cycle, in_ready=0, -> IDLE; final strobe and win_valid still issue per REQ-023/024.
REQ-028 Start and accept in same cycle impossible in IDLE (in_ready=0); Start in DONE ignored.
REQ-029 Back-to-back accepts every cycle sustain one column per cycle with no bubbles.

Reset
REQ-030 Rst_linebuf low: immediately state=IDLE, col=row=0, in_ready, Wr_window, Shift_window, win_valid, frame_done = 0, out_row_* = 0, regardless of state.
REQ-031 Line memory contents need not be cleared; REQ-022 masking guarantees rows 0/1 never expose stale data.
REQ-032 Reset mid-frame abandons the frame; new Start required.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3)
REQ-033 Reset then idle, in_valid=1 -> in_ready=0, no strobes, all outputs 0.
REQ-034 Start, stream pixels 1..12 continuously -> strobes on 12 consecutive cycles; row 2 column 0 strobe gives out_row_n=9, out_row_n_1=5, out_row_n_2=1; win_valid pulses exactly twice (after columns 2,3 of row 2).
REQ-035 Same stream -> row 0 strobes show out_row_n_1=out_row_n_2=0; row 1 column 1 shows 6,2,0.
REQ-036 Pixel 12 accepted -> frame_done pulses 2 cycles later, in_ready=0 from cycle after accept, state returns to IDLE; second Start replays correctly with stale-data masking.
REQ-037 in_valid toggled 1,0,1,0 during row 1 -> strobes only after accepted cycles, counters hold in gaps, values per REQ-021.
REQ-038 Rst_linebuf asserted asynchronously after pixel 7 -> outputs 0 without clock edge; subsequent Start and pixels 1..12 produce REQ-034 results.

Source files
------------

// File: rtl/line_buffer_3row.sv
// Three-row line buffer for raster-order pixel streams: two line memories
// supply the two rows above the current pixel, one column per accepted pixel.
module line_buffer_3row #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                         clk,
    input  logic                         Rst_linebuf,
    input  logic                         Start,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_pixel,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_row_n,
    output logic signed [DATA_WIDTH-1:0] out_row_n_1,
    output logic signed [DATA_WIDTH-1:0] out_row_n_2,
    output logic                         Wr_window,
    output logic                         Shift_window,
    output logic                         win_valid,
    output logic                         frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    logic   [CW-1:0]               r_col;
    logic   [RW-1:0]               r_row;
    logic                          r_win_pend;
    logic signed [DATA_WIDTH-1:0]  r_line1 [0:IMG_WIDTH-1];
    logic signed [DATA_WIDTH-1:0]  r_line2 [0:IMG_WIDTH-1];

    logic                          w_accept;
    logic                          w_col_last;
    logic                          w_row_last;
    logic                          w_win_pos;
    logic signed [DATA_WIDTH-1:0]  w_tap1;
    logic signed [DATA_WIDTH-1:0]  w_tap2;

    // Accept qualification, position flags and masked taps from the line memories
    always_comb begin
        w_accept   = (r_state == ST_RUN) && in_valid;
        w_col_last = (r_col == COL_LAST);
        w_row_last = (r_row == ROW_LAST);
        w_win_pos  = (r_col >= CW'(2)) && (r_row >= RW'(2));
        // Rows that do not exist yet read as zero so stale memory never leaks out
        if (r_row == RW'(0)) begin
            w_tap1 = '0;
        end else begin
            w_tap1 = r_line1[r_col];
        end
        if (r_row < RW'(2)) begin
            w_tap2 = '0;
        end else begin
            w_tap2 = r_line2[r_col];
        end
    end

    // Line memories: push the column down one row on every accepted pixel
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line2[r_col] <= r_line1[r_col];
            r_line1[r_col] <= in_pixel;
        end
    end

    // Frame control FSM with registered handshake, strobes and column taps
    always_ff @(posedge clk or negedge Rst_linebuf) begin
        if (!Rst_linebuf) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_win_pend   <= 1'b0;
            in_ready     <= 1'b0;
            Wr_window    <= 1'b0;
            Shift_window <= 1'b0;
            win_valid    <= 1'b0;
            frame_done   <= 1'b0;
            out_row_n    <= '0;
            out_row_n_1  <= '0;
            out_row_n_2  <= '0;
        end else begin
            Wr_window    <= w_accept;
            Shift_window <= w_accept;
            r_win_pend   <= w_accept && w_win_pos;
            win_valid    <= r_win_pend;
            frame_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state  <= ST_RUN;
                        r_col    <= '0;
                        r_row    <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        out_row_n   <= in_pixel;
                        out_row_n_1 <= w_tap1;
                        out_row_n_2 <= w_tap2;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row    <= '0;
                                r_state  <= ST_DONE;
                                in_ready <= 1'b0;
                            end else begin
                                r_row <= r_row + RW'(1);
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    in_ready   <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Randomised bench for line_buffer_3row on a 4x3 image; expectations come from
// a frame array indexed by (row, column) of each accepted pixel.
module tb_line_buffer_3row;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic                 clk = 1'b0;
    logic                 Rst_linebuf;
    logic                 Start;
    logic                 in_valid;
    logic signed [DW-1:0] in_pixel;
    logic                 in_ready;
    logic signed [DW-1:0] out_row_n;
    logic signed [DW-1:0] out_row_n_1;
    logic signed [DW-1:0] out_row_n_2;
    logic                 Wr_window;
    logic                 Shift_window;
    logic                 win_valid;
    logic                 frame_done;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [DW-1:0] pix [N];
    logic signed [DW-1:0] hold_n, hold_n1, hold_n2;

    always #5 clk = ~clk;

    line_buffer_3row #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk         (clk),
        .Rst_linebuf (Rst_linebuf),
        .Start       (Start),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .in_ready    (in_ready),
        .out_row_n   (out_row_n),
        .out_row_n_1 (out_row_n_1),
        .out_row_n_2 (out_row_n_2),
        .Wr_window   (Wr_window),
        .Shift_window(Shift_window),
        .win_valid   (win_valid),
        .frame_done  (frame_done)
    );

    task automatic test_reset();
        Rst_linebuf = 1'b0;
        Start       = 1'b0;
        in_valid    = 1'b0;
        in_pixel    = '0;
        hold_n      = '0;
        hold_n1     = '0;
        hold_n2     = '0;
        #1;
        n_total++;
        if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== 5'b0 ||
            {out_row_n, out_row_n_1, out_row_n_2} !== {(3*DW){1'b0}}) begin
            $display("FAIL reset_state ctrl=%b data=%h expected all zero",
                     {in_ready, Wr_window, Shift_window, win_valid, frame_done},
                     {out_row_n, out_row_n_1, out_row_n_2});
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        Rst_linebuf = 1'b1;
        // Idle with valid data offered: nothing may be accepted
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pixel = DW'($urandom);
            @(posedge clk);
            #1;
            n_total++;
            if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== 5'b0 ||
                {out_row_n, out_row_n_1, out_row_n_2} !== {(3*DW){1'b0}}) begin
                $display("FAIL idle_no_accept cyc=%0d ctrl=%b data=%h expected all zero", i,
                         {in_ready, Wr_window, Shift_window, win_valid, frame_done},
                         {out_row_n, out_row_n_1, out_row_n_2});
            end else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: continuous, 1: toggle valid during row 1, 2: random valid and Start noise
    task automatic run_frame(input string name, input int mode, input bit seq);
        int   k    = 0;
        int   cyc  = 0;
        int   wins = 0;
        int   r, c;
        bit   v;
        bit   tog  = 1'b1;
        bit   prev_win = 1'b0;
        logic [4:0] exp_ctrl;
        for (int i = 0; i < N; i++) pix[i] = seq ? DW'(i + 1) : DW'($urandom);
        Start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        Start = 1'b0;
        n_total++;
        if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== 5'b10000) begin
            $display("FAIL %s_start ctrl=%b expected 10000", name,
                     {in_ready, Wr_window, Shift_window, win_valid, frame_done});
        end else n_pass++;
        while (k < N && cyc < 200) begin
            case (mode)
                1:       v = (k >= W && k < 2 * W) ? tog : 1'b1;
                2:       v = 1'($urandom_range(0, 1));
                default: v = 1'b1;
            endcase
            tog      = ~tog;
            in_valid = v;
            in_pixel = v ? pix[k] : DW'($urandom);
            Start    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            r = k / W;
            c = k % W;
            if (v) begin
                hold_n  = pix[k];
                hold_n1 = (r >= 1) ? pix[k - W] : '0;
                hold_n2 = (r >= 2) ? pix[k - 2 * W] : '0;
                k++;
            end
            exp_ctrl = {(k < N), v, v, prev_win, 1'b0};
            if (win_valid === 1'b1) wins++;
            n_total++;
            if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== exp_ctrl) begin
                $display("FAIL %s_ctrl k=%0d ctrl=%b expected %b", name, k,
                         {in_ready, Wr_window, Shift_window, win_valid, frame_done}, exp_ctrl);
            end else n_pass++;
            n_total++;
            if ({out_row_n, out_row_n_1, out_row_n_2} !== {hold_n, hold_n1, hold_n2}) begin
                $display("FAIL %s_rows k=%0d got %0d,%0d,%0d expected %0d,%0d,%0d", name, k,
                         out_row_n, out_row_n_1, out_row_n_2, hold_n, hold_n1, hold_n2);
            end else n_pass++;
            prev_win = v && (r >= 2) && (c >= 2);
        end
        Start = 1'b0;
        if (k < N) begin
            n_total++;
            $display("FAIL %s_timeout accepted %0d expected %0d", name, k, N);
        end
        // DONE cycle: Start and valid data must both be ignored
        in_valid = 1'b1;
        in_pixel = DW'($urandom);
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        if (win_valid === 1'b1) wins++;
        exp_ctrl = {1'b0, 1'b0, 1'b0, prev_win, 1'b1};
        n_total++;
        if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== exp_ctrl) begin
            $display("FAIL %s_done ctrl=%b expected %b", name,
                     {in_ready, Wr_window, Shift_window, win_valid, frame_done}, exp_ctrl);
        end else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== 5'b0 ||
            {out_row_n, out_row_n_1, out_row_n_2} !== {hold_n, hold_n1, hold_n2}) begin
            $display("FAIL %s_idle_after ctrl=%b data=%h expected 00000 %h", name,
                     {in_ready, Wr_window, Shift_window, win_valid, frame_done},
                     {out_row_n, out_row_n_1, out_row_n_2}, {hold_n, hold_n1, hold_n2});
        end else n_pass++;
        n_total++;
        if (wins != (W - 2) * (H - 2)) begin
            $display("FAIL %s_win_count got %0d expected %0d", name, wins, (W - 2) * (H - 2));
        end else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        Start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        Start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_pixel = DW'(i + 1);
            @(posedge clk);
            #1;
        end
        #2;
        Rst_linebuf = 1'b0;
        #1;
        n_total++;
        if ({in_ready, Wr_window, Shift_window, win_valid, frame_done} !== 5'b0 ||
            {out_row_n, out_row_n_1, out_row_n_2} !== {(3*DW){1'b0}}) begin
            $display("FAIL async_reset ctrl=%b data=%h expected all zero",
                     {in_ready, Wr_window, Shift_window, win_valid, frame_done},
                     {out_row_n, out_row_n_1, out_row_n_2});
        end else n_pass++;
        in_valid = 1'b0;
        hold_n   = '0;
        hold_n1  = '0;
        hold_n2  = '0;
        @(posedge clk);
        #1;
        Rst_linebuf = 1'b1;
        run_frame("after_reset", 0, 1'b1);
    endtask

    initial begin
        test_reset();
        run_frame("stream", 0, 1'b1);
        run_frame("replay", 0, 1'b0);
        run_frame("gaps", 1, 1'b1);
        for (int i = 0; i < 3; i++) run_frame("random", 2, 1'b0);
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
